// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_alu_ctrl_add4_cla_slice.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module add4_cla_slice
  import nibble_serial_alu_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit CLA slice, LSB nibble first.
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NIBBLES = WIDTH / SLICE_W;
  localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("nibble_serial_alu_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic             cy_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] y_next;
  logic [SLICE_W-1:0] slice_sum;
  logic             slice_cout;

  add4_cla_slice u_slice (
    .a    (a_r[SLICE_W*count +: SLICE_W]),
    .b    (b_r[SLICE_W*count +: SLICE_W]),
    .cin  (cy_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // y with the current nibble merged in, so the final-edge flags see the full result
  always_comb begin
    y_next = y;
    y_next[SLICE_W*count +: SLICE_W] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      count     <= '0;
      cy_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b ^ {WIDTH{sub}};
            cy_r     <= sub;
            count    <= '0;
            y        <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          y    <= y_next;
          cy_r <= slice_cout;
          if (count == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            carry     <= slice_cout;
            overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (y_next[WIDTH-1] != a_r[WIDTH-1]);
            zero      <= (y_next == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed plus random checks of nibble_serial_alu_ctrl against an arithmetic reference.
module tb_nibble_serial_alu_ctrl;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         carry;
  logic         overflow;
  logic         zero;

  int total = 0;
  int bad   = 0;

  nibble_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    res_t r;
    logic [W:0] s;
    int sa, sb, sr;
    if (ts) s = {1'b0, ta} + {1'b0, ~tb} + 17'd1;
    else    s = {1'b0, ta} + {1'b0, tb};
    sa  = int'($signed(ta));
    sb  = int'($signed(tb));
    sr  = ts ? (sa - sb) : (sa + sb);
    r.y = s[W-1:0];
    r.c = s[W];
    r.v = (sr > 32767) || (sr < -32768);
    r.z = (s[W-1:0] == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_y"}, 32'(y), 32'(e.y));
    check({tag, "_carry"}, 32'(carry), 32'(e.c));
    check({tag, "_ovf"}, 32'(overflow), 32'(e.v));
    check({tag, "_zero"}, 32'(zero), 32'(e.z));
  endtask

  // Issue one op, noise the inputs during RUN/DONE, hold the result for 'hold' cycles, then hand off.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input int hold);
    res_t e;
    int lat;
    logic [W-1:0] y_seen;
    e = model(ta, tb, ts);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      in_valid = 1'($urandom);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    check_res(tag, e);
    y_seen = y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check_res({tag, "_hold"}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_handoff_y"}, 32'(y), 32'(y_seen));
  endtask

  initial begin
    res_t q[$];
    res_t e;
    int issued, pulses, last_pulse, fresh;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    rst_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 0);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 0);
    run_op("sub_zero",  16'h1234, 16'h1234, 1'b1, 0);
    run_op("bp_hold",   16'hA5A5, 16'h5A5B, 1'b0, 5);
    run_op("after_bp",  16'h0100, 16'h0200, 1'b1, 0);

    // reset after two nibbles have been processed
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 0);
    check("post_rst_const", 32'(y), 32'h1000);

    for (int i = 0; i < 10; i++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // back-to-back with in_valid and out_ready held high
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    issued = 0; pulses = 0; last_pulse = -1; fresh = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) begin
        if (last_pulse >= 0) check("b2b_spacing", 32'(cyc - last_pulse), 32'd6);
        last_pulse = cyc;
        pulses++;
        if (q.size() > 0) begin
          e = q.pop_front();
          check_res("b2b", e);
        end else begin
          check("b2b_extra_pulse", 32'd1, 32'd0);
        end
      end
      if (in_ready && in_valid) begin
        q.push_back(model(a, b, sub));
        issued++;
        fresh = 1;
      end else if (fresh != 0) begin
        fresh = 0;
        if (issued < 3) begin
          a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_issued", 32'(issued), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
